bcd_scan_ctrl: RTL and testbench

- Multiplexed-display controller for a bank of 7-segment digits sharing one BCD-to-7-segment decoder.
- Holds a packed multi-digit BCD word and time-slices the decoder across digits: one 4-bit code plus one active digit select at a time.
- Provides a tear-free load (new data committed only at frame boundaries), leading-zero blanking and invalid-code flagging.
- Sits between the value source (counter/CPU) and the decoder/anode drivers.

---
 rtl/bcd_scan_ctrl.sv | 140 ++++++++++++++
 tb/tb_bcd_scan_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_ctrl.sv
// Multiplexed 7-segment display controller: time-slices one BCD decoder across
// NUM_DIGITS digits with frame-aligned word updates, leading-zero blanking and error flagging.
module bcd_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 4,
    parameter bit LZ_BLANK   = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_syn,
    input  logic                      load_syn,
    input  logic [4*NUM_DIGITS-1:0]   din,
    input  logic                      enable,
    output logic [3:0]                bcd_out,
    output logic [NUM_DIGITS-1:0]     digit_en_n,
    output logic                      blank,
    output logic                      frame_done,
    output logic                      err
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PC_W  = $clog2(PRESCALE);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(PRESCALE - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                    state, state_next;
    logic [4*NUM_DIGITS-1:0]   disp, disp_next;
    logic [4*NUM_DIGITS-1:0]   pending, pending_next;
    logic                      pend_v, pend_v_next;
    logic [PC_W-1:0]           pcnt, pcnt_next;
    logic [IDX_W-1:0]          idx, idx_next;
    logic                      slot_end, boundary;
    logic [3:0]                cur_digit;
    logic                      upper_zero;
    logic [3:0]                bcd_nxt;
    logic [NUM_DIGITS-1:0]     en_nxt;
    logic                      blank_nxt;
    logic                      err_nxt;

    always_ff @(posedge clk or negedge rst_syn) begin
        if (!rst_syn) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable)  state_next = SCAN;
            SCAN:    if (!enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign slot_end = (state == SCAN) && (pcnt == PC_LAST);
    assign boundary = slot_end && (idx == IDX_LAST) && (state_next == SCAN);

    // A load landing on the frame boundary (or on the exit edge) wins over the staged word.
    always_comb begin
        disp_next    = disp;
        pending_next = pending;
        pend_v_next  = pend_v;
        pcnt_next    = '0;
        idx_next     = '0;
        if (state == IDLE) begin
            if (load_syn) begin
                disp_next   = din;
                pend_v_next = 1'b0;
            end
        end else if (state_next == IDLE) begin
            if (load_syn)    disp_next = din;
            else if (pend_v) disp_next = pending;
            pend_v_next = 1'b0;
        end else begin
            pcnt_next = slot_end ? '0 : pcnt + PC_W'(1);
            if (slot_end) idx_next = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            else          idx_next = idx;
            if (boundary) begin
                if (load_syn)    disp_next = din;
                else if (pend_v) disp_next = pending;
                pend_v_next = 1'b0;
            end else if (load_syn) begin
                pending_next = din;
                pend_v_next  = 1'b1;
            end
        end
    end

    // Outputs are derived from the post-edge word and digit so they change with idx.
    always_comb begin
        cur_digit  = disp_next[4*idx_next +: 4];
        upper_zero = 1'b1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (j >= int'(idx_next) && disp_next[4*j +: 4] != 4'd0) upper_zero = 1'b0;
        end
        bcd_nxt   = 4'd0;
        en_nxt    = '1;
        blank_nxt = 1'b1;
        if (state_next == SCAN) begin
            if (cur_digit > 4'd9) begin
                bcd_nxt = cur_digit;
            end else if (!(LZ_BLANK && idx_next != '0 && upper_zero)) begin
                bcd_nxt          = cur_digit;
                en_nxt[idx_next] = 1'b0;
                blank_nxt        = 1'b0;
            end
        end
        err_nxt = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (disp[4*j +: 4] > 4'd9) err_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_syn) begin
        if (!rst_syn) begin
            disp       <= '0;
            pending    <= '0;
            pend_v     <= 1'b0;
            pcnt       <= '0;
            idx        <= '0;
            bcd_out    <= 4'd0;
            digit_en_n <= '1;
            blank      <= 1'b1;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            disp       <= disp_next;
            pending    <= pending_next;
            pend_v     <= pend_v_next;
            pcnt       <= pcnt_next;
            idx        <= idx_next;
            bcd_out    <= bcd_nxt;
            digit_en_n <= en_nxt;
            blank      <= blank_nxt;
            frame_done <= boundary;
            err        <= err_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Testbench for bcd_scan_ctrl: two instances (leading-zero blanking on/off) checked every
// cycle against a frame-position model, plus hand-computed slot expectations.
module tb_bcd_scan_ctrl;

    localparam int N = 4;
    localparam int P = 4;

    typedef struct packed {
        logic [3:0]   bcd;
        logic [N-1:0] en_n;
        logic         blank;
    } view_t;

    logic          clk = 1'b0;
    logic          rst_syn = 1'b0;
    logic          load_syn = 1'b0;
    logic [15:0]   din = 16'h0;
    logic          enable = 1'b0;
    logic [3:0]    bcd_a, bcd_b;
    logic [N-1:0]  en_a, en_b;
    logic          blank_a, blank_b, fd_a, fd_b, err_a, err_b;

    int checks = 0;
    int passes = 0;

    logic [15:0] m_word = 16'h0;
    logic [15:0] m_staged = 16'h0;
    bit          m_staged_v = 1'b0;
    bit          m_active = 1'b0;
    int          m_tick = 0;
    bit          m_fd = 1'b0;
    bit          m_err = 1'b0;
    bit          model_live = 1'b0;

    always #5 clk = ~clk;

    bcd_scan_ctrl #(.NUM_DIGITS(N), .PRESCALE(P), .LZ_BLANK(1'b1)) dut_a (
        .clk(clk), .rst_syn(rst_syn), .load_syn(load_syn), .din(din), .enable(enable),
        .bcd_out(bcd_a), .digit_en_n(en_a), .blank(blank_a), .frame_done(fd_a), .err(err_a)
    );

    bcd_scan_ctrl #(.NUM_DIGITS(N), .PRESCALE(P), .LZ_BLANK(1'b0)) dut_b (
        .clk(clk), .rst_syn(rst_syn), .load_syn(load_syn), .din(din), .enable(enable),
        .bcd_out(bcd_b), .digit_en_n(en_b), .blank(blank_b), .frame_done(fd_b), .err(err_b)
    );

    function automatic view_t view_of(input logic [15:0] w, input int dig, input bit lz, input bit act);
        view_t v;
        logic [15:0] upper;
        v.bcd   = 4'd0;
        v.en_n  = '1;
        v.blank = 1'b1;
        if (act) begin
            upper = w >> (4 * dig);
            if (upper[3:0] > 4'd9) begin
                v.bcd = upper[3:0];
            end else if (!(lz && dig > 0 && upper == 16'd0)) begin
                v.bcd       = upper[3:0];
                v.en_n[dig] = 1'b0;
                v.blank     = 1'b0;
            end
        end
        return v;
    endfunction

    function automatic bit has_invalid(input logic [15:0] w);
        logic [15:0] s;
        for (int i = 0; i < N; i++) begin
            s = w >> (4 * i);
            if (s[3:0] > 4'd9) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got === want) passes++;
        else $display("[TB] FAIL %s: got %h, want %h", name, got, want);
    endtask

    task automatic checkA(input string tag, input logic [3:0] b, input logic [3:0] e, input logic bl);
        checkOutput({tag, ".bcd"}, 16'(bcd_a), 16'(b));
        checkOutput({tag, ".en_n"}, 16'(en_a), 16'(e));
        checkOutput({tag, ".blank"}, 16'(blank_a), 16'(bl));
    endtask

    task automatic checkB(input string tag, input logic [3:0] b, input logic [3:0] e, input logic bl);
        checkOutput({tag, ".b.bcd"}, 16'(bcd_b), 16'(b));
        checkOutput({tag, ".b.en_n"}, 16'(en_b), 16'(e));
        checkOutput({tag, ".b.blank"}, 16'(blank_b), 16'(bl));
    endtask

    task automatic applyStimulus(input logic ld, input logic [15:0] dn, input logic en);
        load_syn = ld;
        din      = dn;
        enable   = en;
        @(negedge clk);
        load_syn = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model tracks position within the frame as a single tick count; digit = tick / P.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_syn) begin
                m_word = 16'h0; m_staged = 16'h0; m_staged_v = 1'b0;
                m_active = 1'b0; m_tick = 0; m_fd = 1'b0; m_err = 1'b0;
            end else begin
                m_err = has_invalid(m_word);
                m_fd  = 1'b0;
                if (!m_active) begin
                    if (load_syn) begin m_word = din; m_staged_v = 1'b0; end
                    if (enable) begin m_active = 1'b1; m_tick = 0; end
                end else if (!enable) begin
                    if (load_syn)        m_word = din;
                    else if (m_staged_v) m_word = m_staged;
                    m_staged_v = 1'b0;
                    m_active   = 1'b0;
                    m_tick     = 0;
                end else begin
                    m_tick = (m_tick + 1) % (N * P);
                    if (m_tick == 0) begin
                        m_fd = 1'b1;
                        if (load_syn)        m_word = din;
                        else if (m_staged_v) m_word = m_staged;
                        m_staged_v = 1'b0;
                    end else if (load_syn) begin
                        m_staged   = din;
                        m_staged_v = 1'b1;
                    end
                end
            end
            model_live = 1'b1;
        end
    end

    initial begin
        view_t va, vb;
        forever begin
            @(negedge clk);
            if (model_live) begin
                va = view_of(m_word, m_tick / P, 1'b1, m_active);
                vb = view_of(m_word, m_tick / P, 1'b0, m_active);
                checkOutput("model.a.bcd", 16'(bcd_a), 16'(va.bcd));
                checkOutput("model.a.en_n", 16'(en_a), 16'(va.en_n));
                checkOutput("model.a.blank", 16'(blank_a), 16'(va.blank));
                checkOutput("model.b.bcd", 16'(bcd_b), 16'(vb.bcd));
                checkOutput("model.b.en_n", 16'(en_b), 16'(vb.en_n));
                checkOutput("model.b.blank", 16'(blank_b), 16'(vb.blank));
                checkOutput("model.frame_done", 16'({fd_a, fd_b}), 16'({m_fd, m_fd}));
                checkOutput("model.err", 16'({err_a, err_b}), 16'({m_err, m_err}));
            end
        end
    end

    initial begin
        logic [3:0] exp_bcd [4];
        logic [3:0] exp_en  [4];
        bit found;
        int gap;

        step(3);
        checkA("reset", 4'd0, 4'hF, 1'b1);
        checkOutput("reset.fd", 16'(fd_a), 16'd0);
        checkOutput("reset.err", 16'(err_a), 16'd0);

        #2 rst_syn = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        checkA("empty.d0", 4'd0, 4'b1110, 1'b0);
        step(4);
        checkA("empty.d1", 4'd0, 4'b1111, 1'b1);
        checkB("empty.d1", 4'd0, 4'b1101, 1'b0);

        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1);
            if (fd_a) found = 1'b1;
        end
        checkOutput("fd.seen", 16'(found), 16'd1);
        gap = 0;
        for (int i = 1; i <= 40; i++) begin
            step(1);
            if (fd_a) begin gap = i; break; end
        end
        checkOutput("fd.period", 16'(gap), 16'd16);

        applyStimulus(1'b0, 16'h0, 1'b0);
        checkA("idle", 4'd0, 4'hF, 1'b1);
        applyStimulus(1'b1, 16'h1205, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b1);
        exp_bcd = '{4'd5, 4'd0, 4'd2, 4'd1};
        exp_en  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        for (int s = 0; s < 4; s++) begin
            if (s > 0) step(4);
            checkA($sformatf("w1205.slot%0d", s), exp_bcd[s], exp_en[s], 1'b0);
        end

        applyStimulus(1'b1, 16'h0042, 1'b1);
        checkA("stage42.hold", 4'd1, 4'b0111, 1'b0);
        step(3);
        checkA("w0042.d0", 4'd2, 4'b1110, 1'b0);
        checkOutput("w0042.fd", 16'(fd_a), 16'd1);
        step(4);
        checkA("w0042.d1", 4'd4, 4'b1101, 1'b0);
        step(4);
        checkA("w0042.d2", 4'd0, 4'b1111, 1'b1);

        applyStimulus(1'b1, 16'h0777, 1'b1);
        applyStimulus(1'b1, 16'h0031, 1'b1);
        step(6);
        checkA("latest.d0", 4'd1, 4'b1110, 1'b0);
        step(4);
        checkA("latest.d1", 4'd3, 4'b1101, 1'b0);
        step(4);
        checkA("latest.d2", 4'd0, 4'b1111, 1'b1);

        step(7);
        applyStimulus(1'b1, 16'h9876, 1'b1);
        checkA("edgeload.d0", 4'd6, 4'b1110, 1'b0);
        checkOutput("edgeload.fd", 16'(fd_a), 16'd1);

        applyStimulus(1'b1, 16'h00A3, 1'b1);
        step(15);
        checkA("w00A3.d0", 4'd3, 4'b1110, 1'b0);
        checkOutput("w00A3.err_early", 16'(err_a), 16'd0);
        step(1);
        checkOutput("w00A3.err", 16'(err_a), 16'd1);
        step(3);
        checkA("w00A3.d1", 4'hA, 4'b1111, 1'b1);
        applyStimulus(1'b1, 16'h0003, 1'b1);
        step(11);
        checkOutput("w0003.err_hold", 16'(err_a), 16'd1);
        step(1);
        checkOutput("w0003.err", 16'(err_a), 16'd0);

        applyStimulus(1'b1, 16'h5555, 1'b1);
        #2 rst_syn = 1'b0;
        #1;
        checkA("async_rst", 4'd0, 4'hF, 1'b1);
        checkOutput("async_rst.err", 16'(err_a), 16'd0);
        @(negedge clk);
        #2 rst_syn = 1'b1;
        @(negedge clk);
        checkA("post_rst.d0", 4'd0, 4'b1110, 1'b0);
        step(16);
        checkA("post_rst.frame2", 4'd0, 4'b1110, 1'b0);
        checkOutput("post_rst.fd", 16'(fd_a), 16'd1);

        applyStimulus(1'b1, 16'h0404, 1'b1);
        applyStimulus(1'b0, 16'h0, 1'b0);
        checkA("exit", 4'd0, 4'hF, 1'b1);
        applyStimulus(1'b0, 16'h0, 1'b1);
        checkA("exit_commit.d0", 4'd4, 4'b1110, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b0);
        applyStimulus(1'b1, 16'h0007, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b1);
        exp_bcd = '{4'd7, 4'd0, 4'd0, 4'd0};
        for (int s = 0; s < 4; s++) begin
            if (s > 0) step(4);
            checkB($sformatf("nolz.slot%0d", s), exp_bcd[s], exp_en[s], 1'b0);
            if (s == 1) checkA("lz.slot1", 4'd0, 4'hF, 1'b1);
        end

        step(2);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
